// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings:
// PLL lock status and relock request in, resets/status/debug out.
interface pll_lock_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             locked;
   logic             force_relock;
   logic             pll_rst;
   logic             sys_rst;
   logic             ready;
   logic [CNT_W-1:0] retry_count;
   logic [CNT_W-1:0] lock_loss_count;
   logic [1:0]       state_o;

   modport slave (
      input  locked, force_relock,
      output pll_rst, sys_rst, ready, retry_count, lock_loss_count, state_o
   );

   modport master (
      output locked, force_relock,
      input  pll_rst, sys_rst, ready, retry_count, lock_loss_count, state_o
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer in the reference-clock domain: pulses the PLL reset,
// waits for stable lock, then releases the system reset; retries on timeout.
module pll_lock_sequencer #(
   parameter int SYNC_STAGES   = 2,
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int CNT_W         = 8
) (
   input  logic                 refclk,
   input  logic                 rst,
   pll_lock_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      STABILIZE = 2'd2,
      RUN       = 2'd3
   } state_e;

   // One timer serves all states, so it is sized for the longest interval.
   localparam int TMR_MAX =
      (RST_CYCLES > LOCK_TIMEOUT)
         ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
         : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
   localparam int TMR_W = $clog2(TMR_MAX);

   localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);

   state_e                 state_q, state_d;
   logic [TMR_W-1:0]       timer_q, timer_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       retry_q, retry_d;
   logic [CNT_W-1:0]       loss_q, loss_d;
   logic                   pll_rst_q, sys_rst_q, ready_q;
   logic                   lock_s;

   assign lock_s = sync_q[SYNC_STAGES-1];

   // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q + TMR_W'(1);
      retry_d = retry_q;
      loss_d  = loss_q;

      case (state_q)
         PLL_RESET: begin
            if (timer_q == RST_LAST) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = STABILIZE;
            end else if (timer_q == TIMEOUT_LAST) begin
               state_d = PLL_RESET;
               if (retry_q != '1) retry_d = retry_q + CNT_W'(1);
            end
         end
         STABILIZE: begin
            if (!lock_s)                     state_d = WAIT_LOCK;
            else if (timer_q == STABLE_LAST) state_d = RUN;
         end
         RUN: begin
            timer_d = '0;
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
            end
         end
         default: state_d = PLL_RESET;
      endcase

      // A relock request beats every other transition and never counts as an event.
      if (bus.force_relock) begin
         state_d = PLL_RESET;
         retry_d = retry_q;
         loss_d  = loss_q;
      end

      if (state_d != state_q || bus.force_relock) timer_d = '0;
   end

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values, independent of statement order.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q   <= PLL_RESET;
         timer_q   <= '0;
         sync_q    <= '0;
         retry_q   <= '0;
         loss_q    <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.locked};
         retry_q   <= retry_d;
         loss_q    <= loss_d;
         // Outputs decoded from the next state so they switch with the state register.
         pll_rst_q <= (state_d == PLL_RESET);
         sys_rst_q <= (state_d != RUN);
         ready_q   <= (state_d == RUN);
      end
   end

   assign bus.pll_rst         = pll_rst_q;
   assign bus.sys_rst         = sys_rst_q;
   assign bus.ready           = ready_q;
   assign bus.retry_count     = retry_q;
   assign bus.lock_loss_count = loss_q;
   assign bus.state_o         = state_q;

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Companion controller for the 150 MHz system PLL. It drives the PLL's `rst` input, watches the PLL's `locked` output, and releases the downstream system reset only after lock has been continuously stable. It re-issues PLL resets when lock is not reached within a timeout, and re-asserts system reset on loss of lock. It runs in the 50 MHz reference-clock domain, alongside the PLL wrapper at the top level.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for `locked`; minimum 2.
- `RST_CYCLES`, 16: width of the `pll_rst` pulse, in refclk cycles; minimum 1.
- `LOCK_TIMEOUT`, 65536: cycles to wait for lock before retrying; minimum 2.
- `STABLE_CYCLES`, 1024: consecutive locked cycles required before release; minimum 1.
- `CNT_W`, 8: width of the retry and lock-loss counters.

Ports:
- `refclk`  in  1  50 MHz reference clock; all logic is on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `locked`  in  1  PLL lock indicator; asynchronous to `refclk`.
- `force_relock`  in  1  single-cycle request to restart the PLL.
- `pll_rst`  out  1  reset to the PLL, active-high.
- `sys_rst`  out  1  reset to downstream logic, active-high.
- `ready`  out  1  high while in RUN.
- `retry_count`  out  CNT_W  number of lock timeouts; saturates at all-ones.
- `lock_loss_count`  out  CNT_W  number of lock losses from RUN; saturates at all-ones.
- `state_o`  out  2  current state code, for debug.

## Operation
- `locked` is synchronized through a `SYNC_STAGES`-flop chain to give `lock_s`. Only `lock_s` is used.
- State codes: PLL_RESET=0, WAIT_LOCK=1, STABILIZE=2, RUN=3.
- A single timer serves every state. It is cleared on every state transition.
- **PLL_RESET**
  - `pll_rst`=1.
  - After exactly `RST_CYCLES` cycles in this state, go to WAIT_LOCK.
- **WAIT_LOCK**
  - `pll_rst`=0.
  - If `lock_s`=1, go to STABILIZE.
  - Otherwise, when the timer reaches `LOCK_TIMEOUT-1`, go to PLL_RESET and increment `retry_count` (saturating).
  - If `lock_s`=1 in the same cycle the timer expires, lock wins and the next state is STABILIZE.
- **STABILIZE**
  - If `lock_s`=0, go to WAIT_LOCK. This is not counted as a lock loss.
  - After `STABLE_CYCLES` consecutive cycles with `lock_s`=1, go to RUN.
- **RUN**
  - If `lock_s`=0, go to WAIT_LOCK and increment `lock_loss_count` (saturating).
- **force_relock**
  - `force_relock`=1 in any state sends the FSM to PLL_RESET on the next edge.
  - It overrides every other transition.
  - It does not increment either counter.
- Outputs:
  - `sys_rst`=1 in every state except RUN.
  - `ready`=1 only in RUN.
  - `pll_rst`=1 only in PLL_RESET.
  - All outputs are driven directly from flops, updated on the same edge as the state register, so they are glitch-free.
- Counters are cleared only by `rst`.

## Timing
- Reset values while `rst`=1:
  - state=PLL_RESET, timer=0, sync chain=0.
  - `pll_rst`=1, `sys_rst`=1, `ready`=0.
  - `retry_count`=0, `lock_loss_count`=0, `state_o`=0.
- After `rst` deasserts, `pll_rst` stays high for exactly `RST_CYCLES` rising edges.
- `locked` rising to `lock_s` rising takes `SYNC_STAGES` edges.
- `lock_s` first high in WAIT_LOCK to `sys_rst` falling takes 1 + `STABLE_CYCLES` edges. `ready` rises on the same edge.
- `lock_s` falling in RUN to `sys_rst`=1 / `ready`=0 takes 1 edge. `lock_loss_count` updates on that same edge.
- `force_relock` sampled high to `pll_rst`=1 takes 1 edge. If it is asserted during PLL_RESET, the pulse restarts from full length.
- The FSM is Moore-style: no output depends combinationally on any input.
- Asserting `rst` mid-operation forces all reset values immediately, without waiting for a clock edge.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `RST_CYCLES`=4, `LOCK_TIMEOUT`=32, `STABLE_CYCLES`=8.

1. Normal bring-up: release `rst`, raise `locked` 10 cycles later -> `pll_rst` high for 4 cycles; `sys_rst` falls and `ready` rises exactly 2+1+8 cycles after `locked` rises; both counters stay 0.
2. Timeout retry: hold `locked`=0 -> `pll_rst` re-pulses (4 cycles wide) every 36 cycles; `retry_count` reaches 3 after three timeouts; `retry_count` saturates at 255 over a long run.
3. Glitch during STABILIZE: `locked` high for 5 cycles, low for 1, then high -> no `ready` until 8 further consecutive lock cycles; `lock_loss_count`=0.
4. Lock loss in RUN: drop `locked` for 3 cycles -> `sys_rst`=1 two edges after the drop plus one; `lock_loss_count`=1; `ready` returns 1+8 cycles after `lock_s` is high again.
5. `force_relock` in RUN, in the same cycle that `lock_s` falls -> next state PLL_RESET (`state_o`=0); `lock_loss_count` unchanged; `pll_rst` is 4 cycles wide.
6. Async reset mid-STABILIZE: pulse `rst` between clock edges -> outputs take reset values before the next edge; both counters read 0.
